// File: rtl/mem_share_arbiter.sv
// mem_share_arbiter
//   Shares one memory port between the instruction-fetch requester (I) and
//   the data load/store requester (D). Requests pass straight through to
//   memory in the same cycle. An owner-tag FIFO records in order which
//   requester issued each accepted request, so that each in-order memory
//   response can be routed back to its owner. A pipeline flush kills
//   instruction traffic and silently drops responses to in-flight fetches.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   flush                        pipeline flush, kills instruction traffic
//   ireq_*_i / ireq_ready_o      instruction request (a, we, be, d), valid/ready
//   iresp_*_o / iresp_ready_i    instruction response word, valid/ready
//   dreq_*_i / dreq_ready_o      data request (a, we, be, d), valid/ready
//   dresp_*_o / dresp_ready_i    data response word, valid/ready
//   mem_req_*_o / mem_req_ready_i     request to memory, valid/ready
//   mem_resp_*_i / mem_resp_ready_o   in-order response from memory
module mem_share_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   // instruction request / response
   input  logic        ireq_valid_i,
   output logic        ireq_ready_o,
   input  logic [31:0] ireq_a_i,
   input  logic        ireq_we_i,
   input  logic [3:0]  ireq_be_i,
   input  logic [31:0] ireq_d_i,
   output logic        iresp_valid_o,
   input  logic        iresp_ready_i,
   output logic [31:0] iresp_data_o,
   // data request / response
   input  logic        dreq_valid_i,
   output logic        dreq_ready_o,
   input  logic [31:0] dreq_a_i,
   input  logic        dreq_we_i,
   input  logic [3:0]  dreq_be_i,
   input  logic [31:0] dreq_d_i,
   output logic        dresp_valid_o,
   input  logic        dresp_ready_i,
   output logic [31:0] dresp_data_o,
   // memory side
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic [31:0] mem_req_a_o,
   output logic        mem_req_we_o,
   output logic [3:0]  mem_req_be_o,
   output logic [31:0] mem_req_d_o,
   input  logic        mem_resp_valid_i,
   output logic        mem_resp_ready_o,
   input  logic [31:0] mem_resp_data_i
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {LOCK_NONE, LOCK_I, LOCK_D} lock_e;
   typedef enum logic       {SRC_I, SRC_D}              src_e;

   lock_e          lock_q, lock_d;
   logic [SW-1:0]  streak_q, streak_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   src_e           src_q  [MAX_OUTSTANDING];
   src_e           src_d  [MAX_OUTSTANDING];
   logic           drop_q [MAX_OUTSTANDING];
   logic           drop_d [MAX_OUTSTANDING];

   logic full, empty, i_elig, sel_i, req_valid, push, pop, i_fire, d_fire;
   logic resp_ready;
   src_e head_src;
   logic head_drop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // ---------------- request path ----------------
   always_comb begin
      full   = (count_q == FULL_CNT);
      i_elig = ireq_valid_i && !flush;

      // A held lock pins the source; a flush releases an instruction lock,
      // after which the instruction side is ineligible and D is selected.
      unique case (lock_q)
         LOCK_I:  sel_i = !flush;
         LOCK_D:  sel_i = 1'b0;
         default: sel_i = i_elig && (!dreq_valid_i || (streak_q == STREAK_MAX));
      endcase

      req_valid    = !rst && !full && (sel_i ? i_elig : dreq_valid_i);
      ireq_ready_o = !rst && !full &&  sel_i && mem_req_ready_i;
      dreq_ready_o = !rst && !full && !sel_i && mem_req_ready_i;

      mem_req_valid_o = req_valid;
      mem_req_a_o     = sel_i ? ireq_a_i  : dreq_a_i;
      mem_req_we_o    = sel_i ? ireq_we_i : dreq_we_i;
      mem_req_be_o    = sel_i ? ireq_be_i : dreq_be_i;
      mem_req_d_o     = sel_i ? ireq_d_i  : dreq_d_i;

      push   = req_valid && mem_req_ready_i;
      i_fire = push &&  sel_i;
      d_fire = push && !sel_i;
   end

   // ---------------- response routing ----------------
   always_comb begin
      empty     = (count_q == '0);
      head_src  = src_q[head_q];
      head_drop = drop_q[head_q];

      iresp_valid_o = 1'b0;
      dresp_valid_o = 1'b0;
      resp_ready    = 1'b0;
      if (!rst && !empty) begin
         if (head_drop) begin
            resp_ready = 1'b1;
         end else if (head_src == SRC_I) begin
            // A flush arriving while the head fetch response is presented
            // consumes it silently.
            iresp_valid_o = mem_resp_valid_i && !flush;
            resp_ready    = iresp_ready_i || flush;
         end else begin
            dresp_valid_o = mem_resp_valid_i;
            resp_ready    = dresp_ready_i;
         end
      end
      mem_resp_ready_o = resp_ready;
      iresp_data_o     = mem_resp_data_i;
      dresp_data_o     = mem_resp_data_i;
      pop              = mem_resp_valid_i && resp_ready;
   end

   // ---------------- next state ----------------
   always_comb begin
      lock_d = LOCK_NONE;
      if (req_valid && !mem_req_ready_i)
         lock_d = sel_i ? LOCK_I : LOCK_D;

      if (i_fire || !i_elig)
         streak_d = '0;
      else if (d_fire && (streak_q != STREAK_MAX))
         streak_d = streak_q + 1'b1;
      else
         streak_d = streak_q;

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      head_d = pop  ? ptr_inc(head_q) : head_q;
      tail_d = push ? ptr_inc(tail_q) : tail_q;

      // Marking stale (already popped) I slots too is harmless: every push
      // rewrites drop, so only live entries ever have their flag observed.
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
         src_d[i]  = src_q[i];
         drop_d[i] = drop_q[i] || (flush && (src_q[i] == SRC_I));
      end
      if (push) begin
         src_d[tail_q]  = sel_i ? SRC_I : SRC_D;
         drop_d[tail_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q   <= LOCK_NONE;
         streak_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            src_q[i]  <= SRC_I;
            drop_q[i] <= 1'b0;
         end
      end else begin
         lock_q   <= lock_d;
         streak_q <= streak_d;
         count_q  <= count_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            src_q[i]  <= src_d[i];
            drop_q[i] <= drop_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mem_share_arbiter.sv
// tb_mem_share_arbiter
//   Directed bench for mem_share_arbiter (MAX_OUTSTANDING=2, STARVE_LIMIT=4).
//   Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_mem_share_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        ireq_valid = 1'b0, ireq_ready, ireq_we = 1'b0;
   logic [31:0] ireq_a = '0, ireq_d = '0;
   logic [3:0]  ireq_be = '0;
   logic        iresp_valid, iresp_ready = 1'b0;
   logic [31:0] iresp_data;
   logic        dreq_valid = 1'b0, dreq_ready, dreq_we = 1'b0;
   logic [31:0] dreq_a = '0, dreq_d = '0;
   logic [3:0]  dreq_be = '0;
   logic        dresp_valid, dresp_ready = 1'b0;
   logic [31:0] dresp_data;
   logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
   logic [31:0] mem_req_a, mem_req_d;
   logic [3:0]  mem_req_be;
   logic        mem_resp_valid = 1'b0, mem_resp_ready;
   logic [31:0] mem_resp_data = '0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_share_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .ireq_valid_i     (ireq_valid),
      .ireq_ready_o     (ireq_ready),
      .ireq_a_i         (ireq_a),
      .ireq_we_i        (ireq_we),
      .ireq_be_i        (ireq_be),
      .ireq_d_i         (ireq_d),
      .iresp_valid_o    (iresp_valid),
      .iresp_ready_i    (iresp_ready),
      .iresp_data_o     (iresp_data),
      .dreq_valid_i     (dreq_valid),
      .dreq_ready_o     (dreq_ready),
      .dreq_a_i         (dreq_a),
      .dreq_we_i        (dreq_we),
      .dreq_be_i        (dreq_be),
      .dreq_d_i         (dreq_d),
      .dresp_valid_o    (dresp_valid),
      .dresp_ready_i    (dresp_ready),
      .dresp_data_o     (dresp_data),
      .mem_req_valid_o  (mem_req_valid),
      .mem_req_ready_i  (mem_req_ready),
      .mem_req_a_o      (mem_req_a),
      .mem_req_we_o     (mem_req_we),
      .mem_req_be_o     (mem_req_be),
      .mem_req_d_o      (mem_req_d),
      .mem_resp_valid_i (mem_resp_valid),
      .mem_resp_ready_o (mem_resp_ready),
      .mem_resp_data_i  (mem_resp_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ireq_valid = 1'b0; dreq_valid = 1'b0; flush = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      iresp_ready = 1'b0; dresp_ready = 1'b0;
      ireq_we = 1'b0; dreq_we = 1'b0; ireq_be = '0; dreq_be = '0;
   endtask

   // all six handshake outputs, in a fixed order, for compact checks
   function automatic logic [5:0] hs();
      return {mem_req_valid, ireq_ready, dreq_ready, mem_resp_ready, iresp_valid, dresp_valid};
   endfunction

   task automatic test_reset();
      dreq_valid = 1'b1; ireq_valid = 1'b1; mem_req_ready = 1'b1;
      mem_resp_valid = 1'b1; iresp_ready = 1'b1; dresp_ready = 1'b1;
      #2;
      vectors++;
      if (hs() !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b want %b", hs(), 6'b0);
      end
      idle();
      @(posedge clk); #1;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_data_priority();
      logic        exp_i;
      logic [31:0] exp_a;
      ireq_valid = 1'b1; ireq_a = 32'h1000;
      dreq_valid = 1'b1; dreq_a = 32'h2000;
      mem_req_ready = 1'b1; iresp_ready = 1'b1; dresp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         mem_resp_valid = (c > 0);
         mem_resp_data  = 32'hD0 + c;
         #1;
         exp_i = (c == 4);
         exp_a = exp_i ? 32'h1000 : 32'h2000;
         vectors++;
         if ({mem_req_valid, mem_req_a, ireq_ready, dreq_ready} !== {1'b1, exp_a, exp_i, !exp_i}) begin
            miscompares++;
            $display("FAIL priority_c%0d: got v=%b a=%h ir=%b dr=%b want v=1 a=%h ir=%b dr=%b",
                     c, mem_req_valid, mem_req_a, ireq_ready, dreq_ready, exp_a, exp_i, !exp_i);
         end
         tick();
      end
      ireq_valid = 1'b0; dreq_valid = 1'b0;
      mem_resp_valid = 1'b1;
      tick();
      idle();
      tick();
   endtask

   task automatic test_lock_hold_and_full();
      dreq_valid = 1'b1; dreq_a = 32'h100;
      ireq_valid = 1'b1; ireq_a = 32'h200;
      mem_req_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if ({mem_req_valid, mem_req_a, ireq_ready, dreq_ready} !== {1'b1, 32'h100, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL lock_hold_c%0d: got v=%b a=%h ir=%b dr=%b want v=1 a=00000100 ir=0 dr=0",
                     c, mem_req_valid, mem_req_a, ireq_ready, dreq_ready);
         end
         tick();
      end
      mem_req_ready = 1'b1;
      #1;
      vectors++;
      if ({mem_req_a, dreq_ready, ireq_ready} !== {32'h100, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL lock_fire: got a=%h dr=%b ir=%b want a=00000100 dr=1 ir=0",
                  mem_req_a, dreq_ready, ireq_ready);
      end
      tick();
      dreq_valid = 1'b0;
      #1;
      vectors++;
      if ({mem_req_valid, mem_req_a, ireq_ready} !== {1'b1, 32'h200, 1'b1}) begin
         miscompares++;
         $display("FAIL lock_then_i: got v=%b a=%h ir=%b want v=1 a=00000200 ir=1",
                  mem_req_valid, mem_req_a, ireq_ready);
      end
      tick();
      // two outstanding (D then I); a response pops D this cycle, still no accept
      ireq_a = 32'h204;
      dreq_valid = 1'b1; dreq_a = 32'h300;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_1111;
      dresp_ready = 1'b1; iresp_ready = 1'b1;
      #1;
      vectors++;
      if (hs() !== 6'b000101) begin
         miscompares++;
         $display("FAIL full_pop: got %b want %b", hs(), 6'b000101);
      end
      vectors++;
      if (dresp_data !== 32'h1111_1111) begin
         miscompares++;
         $display("FAIL full_pop_data: got %h want 11111111", dresp_data);
      end
      tick();
      mem_resp_data = 32'h2222_2222;
      #1;
      vectors++;
      if ({mem_req_valid, mem_req_a, dreq_ready, ireq_ready, iresp_valid, iresp_data}
          !== {1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h2222_2222}) begin
         miscompares++;
         $display("FAIL after_full: got v=%b a=%h dr=%b ir=%b iv=%b id=%h want v=1 a=00000300 dr=1 ir=0 iv=1 id=22222222",
                  mem_req_valid, mem_req_a, dreq_ready, ireq_ready, iresp_valid, iresp_data);
      end
      tick();
      ireq_valid = 1'b0; dreq_valid = 1'b0;
      mem_resp_data = 32'h3333_3333;
      #1;
      vectors++;
      if ({dresp_valid, dresp_data, iresp_valid} !== {1'b1, 32'h3333_3333, 1'b0}) begin
         miscompares++;
         $display("FAIL full_drain: got dv=%b dd=%h iv=%b want dv=1 dd=33333333 iv=0",
                  dresp_valid, dresp_data, iresp_valid);
      end
      tick();
      idle();
      tick();
   endtask

   task automatic test_ordered_routing();
      mem_req_ready = 1'b1;
      ireq_valid = 1'b1; ireq_a = 32'h0;
      #1;
      vectors++;
      if ({ireq_ready, mem_req_a} !== {1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL route_issue_i: got ir=%b a=%h want ir=1 a=00000000", ireq_ready, mem_req_a);
      end
      tick();
      ireq_valid = 1'b0;
      dreq_valid = 1'b1; dreq_a = 32'h40; dreq_we = 1'b1; dreq_be = 4'h3; dreq_d = 32'hDEAD_BEEF;
      #1;
      vectors++;
      if ({dreq_ready, mem_req_a, mem_req_we, mem_req_be, mem_req_d}
          !== {1'b1, 32'h40, 1'b1, 4'h3, 32'hDEAD_BEEF}) begin
         miscompares++;
         $display("FAIL route_issue_d: got dr=%b a=%h we=%b be=%h d=%h want dr=1 a=00000040 we=1 be=3 d=deadbeef",
                  dreq_ready, mem_req_a, mem_req_we, mem_req_be, mem_req_d);
      end
      tick();
      idle();
      iresp_ready = 1'b1; dresp_ready = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA;
      #1;
      vectors++;
      if ({iresp_valid, iresp_data, dresp_valid} !== {1'b1, 32'hAAAA, 1'b0}) begin
         miscompares++;
         $display("FAIL route_iresp: got iv=%b id=%h dv=%b want iv=1 id=0000aaaa dv=0",
                  iresp_valid, iresp_data, dresp_valid);
      end
      tick();
      mem_resp_data = 32'hBBBB;
      #1;
      vectors++;
      if ({dresp_valid, dresp_data, iresp_valid} !== {1'b1, 32'hBBBB, 1'b0}) begin
         miscompares++;
         $display("FAIL route_dresp: got dv=%b dd=%h iv=%b want dv=1 dd=0000bbbb iv=0",
                  dresp_valid, dresp_data, iresp_valid);
      end
      tick();
      mem_resp_data = 32'hCCCC;
      #1;
      vectors++;
      if (hs() !== 6'b0) begin
         miscompares++;
         $display("FAIL route_empty: got %b want %b", hs(), 6'b0);
      end
      idle();
      tick();
   endtask

   task automatic test_flush_drop();
      mem_req_ready = 1'b1;
      ireq_valid = 1'b1; ireq_a = 32'h10;
      tick();
      ireq_a = 32'h14;
      tick();
      ireq_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h5555;
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if ({mem_resp_ready, iresp_valid, dresp_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL flush_drop_c%0d: got rr=%b iv=%b dv=%b want rr=1 iv=0 dv=0",
                     c, mem_resp_ready, iresp_valid, dresp_valid);
         end
         tick();
      end
      mem_resp_valid = 1'b0;
      ireq_valid = 1'b1; ireq_a = 32'h80;
      #1;
      vectors++;
      if ({ireq_ready, mem_req_valid, mem_req_a} !== {1'b1, 1'b1, 32'h80}) begin
         miscompares++;
         $display("FAIL flush_refetch: got ir=%b v=%b a=%h want ir=1 v=1 a=00000080",
                  ireq_ready, mem_req_valid, mem_req_a);
      end
      tick();
      ireq_valid = 1'b0;
      iresp_ready = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h8080_8080;
      #1;
      vectors++;
      if ({iresp_valid, iresp_data, mem_resp_ready} !== {1'b1, 32'h8080_8080, 1'b1}) begin
         miscompares++;
         $display("FAIL flush_refetch_resp: got iv=%b id=%h rr=%b want iv=1 id=80808080 rr=1",
                  iresp_valid, iresp_data, mem_resp_ready);
      end
      tick();
      idle();
      tick();
   endtask

   task automatic test_reset_midflight();
      mem_req_ready = 1'b1;
      dreq_valid = 1'b1; dreq_a = 32'h500;
      tick();
      mem_resp_valid = 1'b1; dresp_ready = 1'b1; mem_resp_data = 32'h5050;
      rst = 1'b1;
      #1;
      vectors++;
      if (hs() !== 6'b0) begin
         miscompares++;
         $display("FAIL midflight_rst: got %b want %b", hs(), 6'b0);
      end
      tick();
      dreq_valid = 1'b0;
      rst = 1'b0;
      #1;
      vectors++;
      if ({mem_resp_ready, dresp_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL midflight_tag_gone: got rr=%b dv=%b want rr=0 dv=0", mem_resp_ready, dresp_valid);
      end
      mem_resp_valid = 1'b0;
      dreq_valid = 1'b1; dreq_a = 32'h600;
      #1;
      vectors++;
      if ({dreq_ready, mem_req_valid, mem_req_a} !== {1'b1, 1'b1, 32'h600}) begin
         miscompares++;
         $display("FAIL midflight_new_req: got dr=%b v=%b a=%h want dr=1 v=1 a=00000600",
                  dreq_ready, mem_req_valid, mem_req_a);
      end
      tick();
      dreq_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h6666;
      #1;
      vectors++;
      if ({dresp_valid, dresp_data, iresp_valid} !== {1'b1, 32'h6666, 1'b0}) begin
         miscompares++;
         $display("FAIL midflight_resp: got dv=%b dd=%h iv=%b want dv=1 dd=00006666 iv=0",
                  dresp_valid, dresp_data, iresp_valid);
      end
      tick();
      idle();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_data_priority();
      test_lock_hold_and_full();
      test_ordered_routing();
      test_flush_drop();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
